// File: rtl/polyshift_seq.sv
// Multi-cycle barrel shifter that applies up to STEP bits of shift per cycle.
// The valid/ready handshake on each side is handled by an IDLE/SHIFT/DONE sequencer.
module polyshift_seq #(
  parameter int WORD_WIDTH = 16,
  parameter int STEP       = 4,
  localparam int AMT_W     = $clog2(WORD_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0]      in_amt,
  input  logic [2:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_carry
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // SHIFT | applying min(STEP, rem) bits per cycle
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int LW = AMT_W - 1;
  localparam logic [AMT_W-1:0] W_A    = AMT_W'(WORD_WIDTH);
  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);
  localparam logic [2:0] M_LSL = 3'b000;
  localparam logic [2:0] M_LSR = 3'b001;
  localparam logic [2:0] M_ASR = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;

  state_t                  state, state_nxt;
  logic [WORD_WIDTH-1:0]   data_q;
  logic [2:0]              mode_q;
  logic [AMT_W-1:0]        rem;
  logic                    carry_q;

  logic [AMT_W-1:0]        eff_amt;
  logic [AMT_W-1:0]        step_amt;
  logic [WORD_WIDTH:0]     wide_l, wide_r, wide_a;
  logic [2*WORD_WIDTH-1:0] rot_l, rot_r;
  logic [WORD_WIDTH-1:0]   shift_data;
  logic                    shift_carry;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = data_q;
  assign out_carry = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = SHIFT;
      SHIFT:   if (rem <= STEP_A)   state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Rotates wrap modulo the width; linear shifts saturate at a full-width shift.
  always_comb begin
    eff_amt = '0;
    case (in_mode)
      M_LSL, M_LSR, M_ASR: eff_amt = (in_amt > W_A) ? W_A : in_amt;
      M_ROL, M_ROR:        eff_amt = {1'b0, in_amt[LW-1:0]};
      default:             eff_amt = '0;
    endcase
  end

  // The carry of each partial step is the last bit it pushes out, so the carry
  // of the final step equals the carry of the whole shift.
  always_comb begin
    step_amt    = (rem < STEP_A) ? rem : STEP_A;
    wide_l      = {1'b0, data_q} << step_amt;
    wide_r      = {data_q, 1'b0} >> step_amt;
    wide_a      = $signed({data_q, 1'b0}) >>> step_amt;
    rot_l       = {data_q, data_q} << step_amt;
    rot_r       = {data_q, data_q} >> step_amt;
    shift_data  = data_q;
    shift_carry = carry_q;
    if (step_amt != '0) begin
      case (mode_q)
        M_LSL: {shift_carry, shift_data} = wide_l;
        M_LSR: {shift_data, shift_carry} = wide_r;
        M_ASR: {shift_data, shift_carry} = wide_a;
        M_ROL: begin
          shift_data  = rot_l[2*WORD_WIDTH-1:WORD_WIDTH];
          shift_carry = rot_l[WORD_WIDTH];
        end
        M_ROR: begin
          shift_data  = rot_r[WORD_WIDTH-1:0];
          shift_carry = rot_r[WORD_WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      mode_q  <= '0;
      rem     <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data_q  <= in_data;
          mode_q  <= in_mode;
          rem     <= eff_amt;
          carry_q <= 1'b0;
        end
        SHIFT: begin
          data_q  <= shift_data;
          carry_q <= shift_carry;
          rem     <= rem - step_amt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/polyshift_seq.md
POLYSHIFT_SEQ -- requirements
Module: polyshift_seq

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, data width in bits; legal values are powers of 2 from 4 to 64.
REQ-002 SHALL have parameter STEP, default 4, maximum shift distance applied per cycle; legal values are powers of 2 from 1 to WORD_WIDTH.
REQ-003 SHALL define local AMT_W = $clog2(WORD_WIDTH)+1, the shift-amount width, so that amounts 0..WORD_WIDTH are representable.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assertion and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: request present.
REQ-007 SHALL have port in_ready, output, 1 bit: unit can accept a request.
REQ-008 SHALL have port in_data, input, WORD_WIDTH bits: operand.
REQ-009 SHALL have port in_amt, input, AMT_W bits: unsigned shift amount.
REQ-010 SHALL have port in_mode, input, 3 bits: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR; 101-111 are reserved.
REQ-011 SHALL have port out_valid, output, 1 bit: result present.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port out_data, output, WORD_WIDTH bits: shifted result.
REQ-014 SHALL have port out_carry, output, 1 bit: last bit shifted or rotated out.

Function
REQ-015 SHALL implement an FSM with states IDLE, SHIFT and DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-016 SHALL, in IDLE, accept a request when in_valid && in_ready at a clock edge: latch data, mode and effective amount, then go to SHIFT.
REQ-017 SHALL use effective amount: rotates take in_amt mod WORD_WIDTH; LSL, LSR and ASR take min(in_amt, WORD_WIDTH).
REQ-018 SHALL, in SHIFT, apply min(STEP, remaining) bits per cycle and decrement remaining by the same value; SHALL move to DONE in the cycle remaining reaches 0.
REQ-019 SHALL spend N = max(1, ceil(eff_amt/STEP)) cycles in SHIFT, so out_valid rises N edges after the accept edge.
REQ-020 SHALL fill vacated bits with 0 for LSL and LSR, and with the latched operand's MSB for ASR.
REQ-021 SHALL set out_carry as follows:
- LSL: operand bit [WORD_WIDTH-eff].
- LSR and ASR: operand bit [eff-1].
- ROL: result[0]. ROR: result[WORD_WIDTH-1].
- eff==0: 0.
REQ-022 SHALL produce, for LSL/LSR with eff==WORD_WIDTH: result 0, carry per REQ-021. For ASR with eff==WORD_WIDTH: all bits equal the sign, carry = sign.
REQ-023 SHALL treat a reserved mode as passthrough: N=1, out_data = in_data, out_carry = 0.
REQ-024 SHALL hold out_data and out_carry stable while in DONE; DONE goes to IDLE on out_ready, and out_ready is ignored outside DONE.
REQ-025 SHALL never accept a new request in the same cycle the result retires; in_ready rises the cycle after the DONE to IDLE edge. The throughput is one operation per N+2 cycles.
REQ-026 SHALL ignore in_* changes after the accept edge.

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, in_ready=1, out_valid=0, out_data=0, out_carry=0 and the remaining count to 0, asynchronously.
REQ-028 SHALL abandon any in-flight operation on reset from any state, with no result produced afterward.
REQ-029 SHALL have the first accept possible at the first rising edge after rst_n deasserts.

Verification (WORD_WIDTH=16, STEP=4)
REQ-030 SHALL cover: LSL 0x00F3 by 5 -> out_data 0x1E60, carry 0, out_valid 2 cycles after accept.
REQ-031 SHALL cover: ASR 0x8001 by 15 -> 0xFFFF, carry 0, N=4; and LSR 0xABCD by 16 -> 0x0000, carry 1, N=4.
REQ-032 SHALL cover: ROR 0x1234 by 4 -> 0x4123, carry 0, N=1; and ROL 0x1234 by 20 -> 0x2341 (eff=4), carry 1.
REQ-033 SHALL cover: amount 0 on 0x5A5A -> 0x5A5A, carry 0, N=1; and mode 111 -> passthrough.
REQ-034 SHALL cover: out_ready held low for 5 cycles in DONE -> out_data/out_carry stable, in_ready 0; then out_ready pulse -> IDLE, with in_ready 1 the next cycle.
REQ-035 SHALL cover: rst_n pulsed low mid-SHIFT -> immediate IDLE, out_valid 0, in_ready 1; a fresh request afterward completes correctly.
